// File: rtl/cpu_ctrl_fsm.sv
// Control unit for the simple-processor datapath: a four-step sequencer (T0..T3)
// with an internal instruction register and a retired-instruction counter.
module cpu_ctrl_fsm #(
  parameter int RBITS = 3,
  parameter int IRW   = 3 + 2*RBITS,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  run,
  input  logic [IRW-1:0]        din,
  input  logic                  g_nz,
  output logic                  ir_en,
  output logic                  din_out,
  output logic [(2**RBITS)-1:0] rin,
  output logic [(2**RBITS)-1:0] rout,
  output logic                  ain,
  output logic                  gin,
  output logic                  gout,
  output logic [1:0]            alu_op,
  output logic                  done,
  output logic                  illegal,
  output logic                  busy,
  output logic [CNTW-1:0]       instr_count
);

  localparam int NREG = 2**RBITS;

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t           state, state_next;
  logic [IRW-1:0]   ir;
  logic [2:0]       opcode;
  logic [RBITS-1:0] rx, ry;
  logic [NREG-1:0]  rx_dec, ry_dec;

  assign opcode = ir[IRW-1 -: 3];
  assign rx     = ir[2*RBITS-1 -: RBITS];
  assign ry     = ir[RBITS-1:0];
  assign rx_dec = {{(NREG-1){1'b0}}, 1'b1} << rx;
  assign ry_dec = {{(NREG-1){1'b0}}, 1'b1} << ry;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= T0;
      ir          <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (ir_en)
        ir <= din;
      if (done && !illegal)
        instr_count <= instr_count + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  // Every output is forced low while reset is held, even mid-instruction.
  always_comb begin
    state_next = state;
    ir_en      = 1'b0;
    din_out    = 1'b0;
    rin        = '0;
    rout       = '0;
    ain        = 1'b0;
    gin        = 1'b0;
    gout       = 1'b0;
    alu_op     = 2'b00;
    done       = 1'b0;
    illegal    = 1'b0;
    busy       = 1'b0;
    if (resetn) begin
      busy = (state != T0);
      unique case (state)
        T0: begin
          if (run) begin
            ir_en      = 1'b1;
            state_next = T1;
          end
        end
        T1: begin
          case (opcode)
            3'b000: begin
              rout       = ry_dec;
              rin        = rx_dec;
              done       = 1'b1;
              state_next = T0;
            end
            3'b001: begin
              din_out    = 1'b1;
              rin        = rx_dec;
              done       = 1'b1;
              state_next = T0;
            end
            3'b101: begin
              if (g_nz) begin
                rout = ry_dec;
                rin  = rx_dec;
              end
              done       = 1'b1;
              state_next = T0;
            end
            3'b111: begin
              done       = 1'b1;
              illegal    = 1'b1;
              state_next = T0;
            end
            default: begin
              rout       = rx_dec;
              ain        = 1'b1;
              state_next = T2;
            end
          endcase
        end
        T2: begin
          rout = ry_dec;
          gin  = 1'b1;
          case (opcode)
            3'b011:  alu_op = 2'b01;
            3'b100:  alu_op = 2'b10;
            3'b110:  alu_op = 2'b11;
            default: alu_op = 2'b00;
          endcase
          state_next = T3;
        end
        T3: begin
          gout       = 1'b1;
          rin        = rx_dec;
          done       = 1'b1;
          state_next = T0;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

- Parametrised control unit for the simple-processor datapath, and the successor to the fixed 8-register, externally-stepped control unit.
- Contains its own step state machine and instruction register, and sizes its one-hot register enables by `RBITS`.
- Adds AND, XOR and conditional move (mvnz) operations, a retired-instruction counter and an illegal-opcode flag.
- Sits between the instruction/data input `din` and the register-file, A, G and ALU controls of the datapath.

## Interface
Parameters:
- `RBITS`, default 3: register index width. NREG = 2**RBITS.
- `IRW`, default 3+2*RBITS: instruction width. Layout: opcode [IRW-1:IRW-3], Rx [2*RBITS-1:RBITS], Ry [RBITS-1:0].
- `CNTW`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  the only clock. All state changes on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `run`  in  1  start request. Sampled only in T0.
- `din`  in  IRW  instruction word, captured into the internal IR on the fetch edge.
- `g_nz`  in  1  G register is non-zero. Used by mvnz.
- `ir_en`  out  1  fetch strobe, =1 in T0 when `run`=1.
- `din_out`  out  1  drive `din` onto the bus (mvi data).
- `rin`  out  NREG  one-hot register write enables.
- `rout`  out  NREG  one-hot register bus drivers.
- `ain`, `gin`, `gout`  out  1 each  A load, G load, G bus drive.
- `alu_op`  out  2  ALU function: 00 add, 01 sub, 10 and, 11 xor.
- `done`  out  1  final cycle of an instruction.
- `illegal`  out  1  reserved opcode retired.
- `busy`  out  1  state ≠ T0.
- `instr_count`  out  CNTW  count of legal instructions retired.

## Operation
- States are T0 (idle/fetch), T1, T2 and T3.
- All outputs except `instr_count` are combinational decodes of state + IR. Every output not listed as asserted for a state is 0.
- **T0**
  - If `run`=1: `ir_en`=1, IR ← `din`, next state T1.
  - Otherwise stay in T0 with all outputs 0.
- **T1, by opcode**
  - 000 mv: `rout`=dec(Ry), `rin`=dec(Rx), `done`=1 → T0.
  - 001 mvi: `din_out`=1, `rin`=dec(Rx), `done`=1 → T0.
  - 101 mvnz: `done`=1 → T0. If `g_nz`=1, also `rout`=dec(Ry) and `rin`=dec(Rx); otherwise `rin`=`rout`=0.
  - 010 add, 011 sub, 100 and, 110 xor: `rout`=dec(Rx), `ain`=1 → T2.
  - 111 reserved: `done`=1, `illegal`=1, no enables → T0.
- **T2:** `rout`=dec(Ry), `gin`=1, `alu_op` from opcode (add 00, sub 01, and 10, xor 11) → T3.
  - Outside T2, `alu_op`=00.
- **T3:** `gout`=1, `rin`=dec(Rx), `done`=1 → T0.
- `instr_count` increments by 1 on each edge where `done`=1 and `illegal`=0. It wraps from 2**CNTW−1 to 0.
- `run` is ignored outside T0. A held `run` fetches a new instruction in every T0 cycle.
- For Rx=Ry, the same one-hot bit is set in both `rin` and `rout`. This is legal.
- `rin` and `rout` are always one-hot or zero, and never carry more than one bit each.

## Timing
- **Reset:** `resetn`=0 at a rising edge sets state=T0, IR=0 and `instr_count`=0.
  - While `resetn`=0 during the cycle, all outputs are 0, including `ir_en`, regardless of `run`.
- **Reset mid-instruction:** aborts the instruction. No `done` is produced and the count is unchanged. The first cycle after reset release is T0.
- **Latency, from the fetch edge:**
  - mv, mvi, mvnz and reserved: `done` in the next cycle (T1).
  - ALU ops: `done` in the third cycle (T3).
- **Throughput:**
  - Short ops: 2 cycles per instruction with `run` held.
  - ALU ops: 4 cycles per instruction with `run` held.
- **Handshake:**
  - `done` is high for exactly one cycle.
  - `busy` rises the cycle after fetch and falls in the cycle after `done`.

## Test plan
Defaults RBITS=3, IRW=9.
- **Reset:** `resetn`=0 for 2 cycles with `run`=1 and `din`=9'h015 → all outputs 0, `instr_count`=0. After release with `run`=1, `ir_en`=1 in the first cycle.
- **mv R2,R5:** `din`=9'b000_010_101, 1-cycle `run` pulse → next cycle `rout`=8'h20, `rin`=8'h04, `done`=1. The cycle after, all outputs are 0 and `instr_count`=1.
- **sub R1,R3:** `din`=9'b011_001_011 →
  - T1: `rout`=8'h02, `ain`=1.
  - T2: `rout`=8'h08, `gin`=1, `alu_op`=01.
  - T3: `gout`=1, `rin`=8'h02, `done`=1.
- **mvnz R4,R0:** `din`=9'b101_100_000.
  - With `g_nz`=0 → `done`=1, `rin`=`rout`=0.
  - Repeated with `g_nz`=1 → `rin`=8'h10, `rout`=8'h01.
  - `instr_count` increases by 2 in total.
- **Reset during xor:** pull `resetn` low in T2 → next cycle all outputs 0, `done` never asserted, `instr_count` unchanged. Then mvi R7 (`din`=9'b001_111_000) completes normally with `din_out`=1 and `rin`=8'h80.
- **Reserved opcode and wrap:** CNTW=4.
  - `din`=9'b111_000_000 → T1 `done`=1, `illegal`=1, count unchanged.
  - Then 16 back-to-back mv with `run` held → `done` every 2nd cycle and `instr_count` wraps to 0.
